y_mc_ctrl: RTL and testbench
============================

Y_MC_CTRL -- requirements
Module: y_mc_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_POINT, default 32'd128, PC value presented on entryPoint.
REQ-002 SHALL have parameter MAX_INSTR, default 43, number of instructions retired before halting; 0 means unlimited.
REQ-003 SHALL have parameter CNT_W, default 16, width of retired counter.
REQ-004 a  input  1  clock; one clock, all state updates on rising edge.
REQ-005 INTn  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  level; 1 permits instruction issue.
REQ-007 ins  input  32  instruction word from fetch stage.
REQ-008 zero  input  1  ALU zero flag, used in beq.
REQ-009 RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  output  1 each  datapath controls.
REQ-010 op  output  3  ALU op: and 000, or 001, add 010, sub 110, slt 111.
REQ-011 branch, jump, PCWrite, IRWrite, INT  output  1 each  PC/IR controls; INT selects entryPoint in PC mux.
REQ-012 entryPoint  output  32  constant ENTRY_POINT.
REQ-013 halted, err  output  1 each  sticky status.
REQ-014 retired  output  CNT_W  instructions retired since reset.
REQ-015 state  output  3  encoded FSM state: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; all control outputs combinational from state and latched opcode/funct.
REQ-017 IDLE -> FETCH when run=1 and halted=0; otherwise stay.
REQ-018 FETCH: IRWrite=1; ins[31:26] and ins[5:0] latched at edge; next DECODE.
REQ-019 DECODE: unsupported opcode (not 0x00, 0x02, 0x04, 0x08, 0x23, 0x2b) or R-type funct not in {0x20,0x22,0x24,0x25,0x2a} -> HALT with err=1, no PCWrite.
REQ-020 Sequence/latency: R-type and addi FETCH-DECODE-EXEC-WB (4 cycles); lw FETCH-DECODE-EXEC-MEM-WB (5); sw FETCH-DECODE-EXEC-MEM (4); beq and j FETCH-DECODE-EXEC (3).
REQ-021 R-type: RegDst=1, ALUSrc=0, op from funct; RegWrite=1 in WB only.
REQ-022 addi: ALUSrc=1, op=010, RegWrite=1 in WB. lw: ALUSrc=1, op=010, MemRead=1 in MEM, Mem2Reg=1 and RegWrite=1 in WB. sw: ALUSrc=1, op=010, MemWrite=1 in MEM only.
REQ-023 beq: ALUSrc=0, op=110, branch=1 in EXEC; PC mux uses zero sampled same cycle. j: jump=1 in EXEC.
REQ-024 PCWrite=1 exactly one cycle per instruction, in its final state; retired increments on that edge.
REQ-025 All controls not listed for a state SHALL be 0; op=010 default.
REQ-026 After final state: if MAX_INSTR!=0 and retired+1==MAX_INSTR -> HALT with halted=1; else if run=1 -> FETCH; else IDLE.
REQ-027 run deasserted mid-instruction SHALL NOT abort it; stop takes effect only at instruction boundary.
REQ-028 retired SHALL saturate at all-ones, never wrap.
REQ-029 HALT is absorbing until INTn=0; all write controls 0 in HALT.

Reset
REQ-030 INTn=0 at a rising edge: state=IDLE, retired=0, halted=0, err=0, latched opcode/funct=0, next cycle.
REQ-031 INT=1 while INTn=0 and for the one IDLE cycle after reset release, else 0; PCWrite=1 with INT=1 in that cycle to load entryPoint.
REQ-032 Reset mid-instruction SHALL abandon it: no PCWrite, RegWrite, MemWrite, and no retired increment on reset edge.

Verification
REQ-033 add $3,$1,$2 (0x00221820), run=1 -> states 1,2,3,5; RegWrite=1 only in WB, op=010, PCWrite once, retired 0->1.
REQ-034 lw 0x8C220004 then sw 0xAC220008 -> lw 5 cycles MemRead in MEM, Mem2Reg+RegWrite in WB; sw 4 cycles MemWrite in MEM only; retired=2.
REQ-035 beq 0x10220003 with zero=1 then j 0x08000020 -> each 3 cycles, branch=1 then jump=1 in EXEC with PCWrite=1.
REQ-036 MAX_INSTR=3, stream of addi 0x20010005 -> retired=3, halted=1, state=6, no further IRWrite while run=1.
REQ-037 opcode 0x3F in FETCH -> DECODE then HALT, err=1, retired unchanged, no PCWrite.
REQ-038 INTn=0 during lw MEM cycle -> next cycle state=0, retired=0, MemRead=0, RegWrite=0; INT=1 and PCWrite=1 in first post-release cycle.

Source files
------------

// File: rtl/y_mc_ctrl.sv
// Multicycle control FSM for a small MIPS subset: sequences each instruction,
// counts retirements, halts on a retire limit or an unsupported encoding.
module y_mc_ctrl #(
   parameter logic [31:0] ENTRY_POINT = 32'd128,
   parameter int          MAX_INSTR   = 43,
   parameter int          CNT_W       = 16
) (
   input  logic             a,
   input  logic             INTn,
   input  logic             run,
   input  logic [31:0]      ins,
   input  logic             zero,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             Mem2Reg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [2:0]       op,
   output logic             branch,
   output logic             jump,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             INT,
   output logic [31:0]      entryPoint,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_INSTR);

   state_t           cur;
   logic [5:0]       opc;
   logic [5:0]       fn;
   logic             post_rst;
   logic             halted_r;
   logic             err_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   ret_inc;
   logic             is_r, is_addi, is_lw, is_sw, is_beq, is_j;
   logic             fn_ok, legal, last;
   logic             reg_dst, reg_wr, alu_src, mem2reg, mem_rd, mem_wr;
   logic             br, jmp, ir_wr;
   logic [2:0]       alu;
   logic             unused_in;

   function automatic logic [2:0] alu_op(input logic [5:0] f);
      case (f)
         6'h20:   alu_op = 3'b010;
         6'h22:   alu_op = 3'b110;
         6'h24:   alu_op = 3'b000;
         6'h25:   alu_op = 3'b001;
         6'h2a:   alu_op = 3'b111;
         default: alu_op = 3'b010;
      endcase
   endfunction

   assign is_r    = (opc == 6'h00);
   assign is_j    = (opc == 6'h02);
   assign is_beq  = (opc == 6'h04);
   assign is_addi = (opc == 6'h08);
   assign is_lw   = (opc == 6'h23);
   assign is_sw   = (opc == 6'h2b);
   assign fn_ok   = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
   assign legal   = (is_r && fn_ok) || is_j || is_beq || is_addi || is_lw || is_sw;
   assign ret_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

   // zero feeds the PC mux outside this block; ins[25:6] belong to the datapath
   assign unused_in = &{1'b0, zero, ins[25:6]};

   always_comb begin
      last = 1'b0;
      case (cur)
         S_EXEC:  last = is_beq || is_j;
         S_MEM:   last = is_sw;
         S_WB:    last = 1'b1;
         default: last = 1'b0;
      endcase
   end

   always_ff @(posedge a) begin
      if (!INTn) begin
         cur      <= S_IDLE;
         cnt      <= '0;
         halted_r <= 1'b0;
         err_r    <= 1'b0;
         opc      <= '0;
         fn       <= '0;
         post_rst <= 1'b1;
      end else begin
         post_rst <= 1'b0;
         if (last) begin
            if (cnt != '1) cnt <= ret_inc[CNT_W-1:0];
            if (MAX_INSTR != 0 && ret_inc == MAX_C) begin
               cur      <= S_HALT;
               halted_r <= 1'b1;
            end else if (run) begin
               cur <= S_FETCH;
            end else begin
               cur <= S_IDLE;
            end
         end else begin
            case (cur)
               S_IDLE:   if (run && !halted_r) cur <= S_FETCH;
               S_FETCH: begin
                  opc <= ins[31:26];
                  fn  <= ins[5:0];
                  cur <= S_DECODE;
               end
               S_DECODE: begin
                  if (legal) begin
                     cur <= S_EXEC;
                  end else begin
                     cur   <= S_HALT;
                     err_r <= 1'b1;
                  end
               end
               S_EXEC:   cur <= (is_lw || is_sw) ? S_MEM : S_WB;
               S_MEM:    cur <= S_WB;
               default:  cur <= cur;
            endcase
         end
      end
   end

   always_comb begin
      reg_dst = 1'b0;
      reg_wr  = 1'b0;
      alu_src = 1'b0;
      mem2reg = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      br      = 1'b0;
      jmp     = 1'b0;
      ir_wr   = 1'b0;
      alu     = 3'b010;
      case (cur)
         S_FETCH: ir_wr = 1'b1;
         S_EXEC: begin
            if (is_r) begin
               reg_dst = 1'b1;
               alu     = alu_op(fn);
            end
            if (is_addi || is_lw || is_sw) alu_src = 1'b1;
            if (is_beq) begin
               br  = 1'b1;
               alu = 3'b110;
            end
            if (is_j) jmp = 1'b1;
         end
         S_MEM: begin
            mem_rd = is_lw;
            mem_wr = is_sw;
         end
         S_WB: begin
            reg_wr  = 1'b1;
            reg_dst = is_r;
            mem2reg = is_lw;
         end
         default: ;
      endcase
   end

   // Write strobes are masked while INTn is low so a reset edge commits nothing.
   assign RegDst     = reg_dst;
   assign RegWrite   = reg_wr && INTn;
   assign ALUSrc     = alu_src;
   assign Mem2Reg    = mem2reg;
   assign MemRead    = mem_rd;
   assign MemWrite   = mem_wr && INTn;
   assign op         = alu;
   assign branch     = br;
   assign jump       = jmp;
   assign IRWrite    = ir_wr && INTn;
   assign PCWrite    = INTn && (last || post_rst);
   assign INT        = !INTn || post_rst;
   assign entryPoint = ENTRY_POINT;
   assign halted     = halted_r;
   assign err        = err_r;
   assign retired    = cnt;
   assign state      = cur;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Bench for y_mc_ctrl: directed vector table, limit/saturation sequence, and
// randomized instruction stream against a path-based reference model.
module tb_y_mc_ctrl;

   localparam int M0   = 43;
   localparam int CMAX = 65535;
   localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_BAD = 6;

   typedef struct packed {
      logic [2:0] state;
      logic regdst, regwrite, alusrc, mem2reg, memread, memwrite;
      logic [2:0] op;
      logic branch, jump, pcwrite, irwrite, intsel, halted, err;
   } obs_t;

   typedef struct {
      logic        intn;
      logic        run;
      logic [31:0] ins;
      logic        zero;
      obs_t        e;
      int          ret;
   } vec_t;

   logic        a = 1'b0;
   logic        INTn, run, zero;
   logic [31:0] ins;
   logic        rd[3], rw[3], asrc[3], m2r[3], mr[3], mw[3];
   logic        br[3], jp[3], pcw[3], irw[3], intr[3], hl[3], er[3];
   logic [2:0]  op[3], st[3];
   logic [31:0] ep[3];
   logic [15:0] ret0, ret1;
   logic [1:0]  ret2;
   obs_t        ob[3];

   always #5 a = ~a;

   y_mc_ctrl u0 (.a(a), .INTn(INTn), .run(run), .ins(ins), .zero(zero),
      .RegDst(rd[0]), .RegWrite(rw[0]), .ALUSrc(asrc[0]), .Mem2Reg(m2r[0]),
      .MemRead(mr[0]), .MemWrite(mw[0]), .op(op[0]), .branch(br[0]), .jump(jp[0]),
      .PCWrite(pcw[0]), .IRWrite(irw[0]), .INT(intr[0]), .entryPoint(ep[0]),
      .halted(hl[0]), .err(er[0]), .retired(ret0), .state(st[0]));

   y_mc_ctrl #(.MAX_INSTR(3)) u1 (.a(a), .INTn(INTn), .run(run), .ins(ins), .zero(zero),
      .RegDst(rd[1]), .RegWrite(rw[1]), .ALUSrc(asrc[1]), .Mem2Reg(m2r[1]),
      .MemRead(mr[1]), .MemWrite(mw[1]), .op(op[1]), .branch(br[1]), .jump(jp[1]),
      .PCWrite(pcw[1]), .IRWrite(irw[1]), .INT(intr[1]), .entryPoint(ep[1]),
      .halted(hl[1]), .err(er[1]), .retired(ret1), .state(st[1]));

   y_mc_ctrl #(.MAX_INSTR(0), .CNT_W(2)) u2 (.a(a), .INTn(INTn), .run(run), .ins(ins), .zero(zero),
      .RegDst(rd[2]), .RegWrite(rw[2]), .ALUSrc(asrc[2]), .Mem2Reg(m2r[2]),
      .MemRead(mr[2]), .MemWrite(mw[2]), .op(op[2]), .branch(br[2]), .jump(jp[2]),
      .PCWrite(pcw[2]), .IRWrite(irw[2]), .INT(intr[2]), .entryPoint(ep[2]),
      .halted(hl[2]), .err(er[2]), .retired(ret2), .state(st[2]));

   for (genvar g = 0; g < 3; g++) begin : g_obs
      assign ob[g] = {st[g], rd[g], rw[g], asrc[g], m2r[g], mr[g], mw[g], op[g],
                      br[g], jp[g], pcw[g], irw[g], intr[g], hl[g], er[g]};
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Letters: D RegDst, W RegWrite, A ALUSrc, M Mem2Reg, R MemRead, S MemWrite,
   // B branch, J jump, P PCWrite, I IRWrite, N INT, H halted, E err.
   function automatic obs_t ex(int s, string f, logic [2:0] o = 3'b010);
      obs_t x = '0;
      x.state = 3'(s);
      x.op    = o;
      for (int i = 0; i < f.len(); i++) begin
         case (f[i])
            "D": x.regdst   = 1'b1;
            "W": x.regwrite = 1'b1;
            "A": x.alusrc   = 1'b1;
            "M": x.mem2reg  = 1'b1;
            "R": x.memread  = 1'b1;
            "S": x.memwrite = 1'b1;
            "B": x.branch   = 1'b1;
            "J": x.jump     = 1'b1;
            "P": x.pcwrite  = 1'b1;
            "I": x.irwrite  = 1'b1;
            "N": x.intsel   = 1'b1;
            "H": x.halted   = 1'b1;
            "E": x.err      = 1'b1;
            default: ;
         endcase
      end
      return x;
   endfunction

   vec_t vt[$];

   task automatic v(logic i_, logic r_, logic [31:0] in_, logic z_, obs_t e_, int ret_);
      vec_t t;
      t.intn = i_; t.run = r_; t.ins = in_; t.zero = z_; t.e = e_; t.ret = ret_;
      vt.push_back(t);
   endtask

   // ---------------- reference model ----------------
   int         m_st, m_cls, m_ret;
   logic [5:0] m_fn;
   bit         m_post, m_halted, m_err, m_inst;
   int         m_path[$];

   function automatic int classify(logic [31:0] w);
      logic [5:0] o, f;
      o = w[31:26];
      f = w[5:0];
      case (o)
         6'h00:   return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) ? C_R : C_BAD;
         6'h08:   return C_ADDI;
         6'h23:   return C_LW;
         6'h2b:   return C_SW;
         6'h04:   return C_BEQ;
         6'h02:   return C_J;
         default: return C_BAD;
      endcase
   endfunction

   function automatic logic [2:0] alu_of(logic [5:0] f);
      case (f)
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2a:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic obs_t model_obs(logic intn);
      obs_t o = '0;
      o.state = 3'(m_st);
      o.op    = 3'b010;
      case (m_st)
         1: o.irwrite = intn;
         3: case (m_cls)
               C_R: begin o.regdst = 1'b1; o.op = alu_of(m_fn); end
               C_ADDI, C_LW, C_SW: o.alusrc = 1'b1;
               C_BEQ: begin o.branch = 1'b1; o.op = 3'b110; end
               C_J: o.jump = 1'b1;
               default: ;
            endcase
         4: begin
            o.memread  = (m_cls == C_LW);
            o.memwrite = intn && (m_cls == C_SW);
         end
         5: begin
            o.regwrite = intn;
            o.regdst   = (m_cls == C_R);
            o.mem2reg  = (m_cls == C_LW);
         end
         default: ;
      endcase
      o.pcwrite = intn && ((m_inst && m_path.size() == 0) || m_post);
      o.intsel  = !intn || m_post;
      o.halted  = m_halted;
      o.err     = m_err;
      return o;
   endfunction

   task automatic model_edge(logic intn, logic r, logic [31:0] w);
      if (!intn) begin
         m_st = 0; m_ret = 0; m_halted = 0; m_err = 0; m_post = 1;
         m_inst = 0; m_fn = '0; m_cls = C_BAD; m_path.delete();
      end else begin
         m_post = 0;
         if (m_inst && m_path.size() == 0) begin
            if (m_ret < CMAX) m_ret++;
            m_inst = 0;
            if (m_ret == M0) begin m_st = 6; m_halted = 1; end
            else m_st = r ? 1 : 0;
         end else if (m_st == 0) begin
            if (r && !m_halted) m_st = 1;
         end else if (m_st == 1) begin
            m_cls  = classify(w);
            m_fn   = w[5:0];
            m_inst = 1;
            m_st   = 2;
            case (m_cls)
               C_R, C_ADDI: m_path = {3, 5};
               C_LW:        m_path = {3, 4, 5};
               C_SW:        m_path = {3, 4};
               C_BEQ, C_J:  m_path = {3};
               default:     m_path = {6};
            endcase
         end else if (m_st != 6) begin
            m_st = m_path.pop_front();
            if (m_st == 6) begin m_err = 1; m_inst = 0; end
         end
      end
   endtask

   function automatic logic [31:0] rnd_ins();
      logic [31:0] r;
      logic [5:0]  o, f;
      int          k;
      r = $urandom();
      k = $urandom_range(0, 29);
      if (k == 28) begin
         do o = 6'($urandom_range(0, 63));
         while (o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b});
         return {o, r[25:0]};
      end
      if (k == 29) begin
         case ($urandom_range(0, 2))
            0:       f = 6'h00;
            1:       f = 6'h21;
            default: f = 6'h27;
         endcase
         return {6'h00, r[25:6], f};
      end
      case (k % 6)
         0: begin
            case ($urandom_range(0, 4))
               0:       f = 6'h20;
               1:       f = 6'h22;
               2:       f = 6'h24;
               3:       f = 6'h25;
               default: f = 6'h2a;
            endcase
            return {6'h00, r[25:6], f};
         end
         1:       return {6'h08, r[25:0]};
         2:       return {6'h23, r[25:0]};
         3:       return {6'h2b, r[25:0]};
         4:       return {6'h04, r[25:0]};
         default: return {6'h02, r[25:0]};
      endcase
   endfunction

   localparam logic [31:0] ADD  = 32'h00221820;
   localparam logic [31:0] LW   = 32'h8C220004;
   localparam logic [31:0] SW   = 32'hAC220008;
   localparam logic [31:0] BEQ  = 32'h10220003;
   localparam logic [31:0] JMP  = 32'h08000020;
   localparam logic [31:0] BAD  = 32'hFC000000;
   localparam logic [31:0] BADF = 32'h00221821;
   localparam logic [31:0] ADDI = 32'h20010005;

   initial begin
      int   irw_cnt, hc;
      obs_t e;
      INTn = 1'b0; run = 1'b0; ins = '0; zero = 1'b0;
      repeat (2) @(posedge a);

      v(0, 0, 0,    0, ex(0, "N"), 0);
      v(1, 1, ADD,  0, ex(0, "NP"), 0);
      v(1, 1, ADD,  0, ex(1, "I"), 0);
      v(1, 1, 0,    0, ex(2, ""), 0);
      v(1, 1, 0,    0, ex(3, "D"), 0);
      v(1, 1, 0,    0, ex(5, "DWP"), 0);
      v(1, 1, LW,   0, ex(1, "I"), 1);
      v(1, 1, 0,    0, ex(2, ""), 1);
      v(1, 1, 0,    0, ex(3, "A"), 1);
      v(1, 1, 0,    0, ex(4, "R"), 1);
      v(1, 1, 0,    0, ex(5, "MWP"), 1);
      v(1, 1, SW,   0, ex(1, "I"), 2);
      v(1, 1, 0,    0, ex(2, ""), 2);
      v(1, 1, 0,    0, ex(3, "A"), 2);
      v(1, 1, 0,    0, ex(4, "SP"), 2);
      v(1, 1, BEQ,  1, ex(1, "I"), 3);
      v(1, 1, 0,    1, ex(2, ""), 3);
      v(1, 1, 0,    1, ex(3, "BP", 3'b110), 3);
      v(1, 1, JMP,  0, ex(1, "I"), 4);
      v(1, 1, 0,    0, ex(2, ""), 4);
      v(1, 0, 0,    0, ex(3, "JP"), 4);
      v(1, 0, 0,    0, ex(0, ""), 5);
      v(1, 1, 0,    0, ex(0, ""), 5);
      v(1, 1, BAD,  0, ex(1, "I"), 5);
      v(1, 1, 0,    0, ex(2, ""), 5);
      v(1, 1, 0,    0, ex(6, "E"), 5);
      v(1, 1, 0,    0, ex(6, "E"), 5);
      v(0, 1, 0,    0, ex(6, "EN"), 5);
      v(1, 1, 0,    0, ex(0, "NP"), 0);
      v(1, 1, LW,   0, ex(1, "I"), 0);
      v(1, 1, 0,    0, ex(2, ""), 0);
      v(1, 1, 0,    0, ex(3, "A"), 0);
      v(0, 1, 0,    0, ex(4, "RN"), 0);
      v(1, 0, 0,    0, ex(0, "NP"), 0);
      v(1, 0, 0,    0, ex(0, ""), 0);
      v(1, 1, 0,    0, ex(0, ""), 0);
      v(1, 1, BADF, 0, ex(1, "I"), 0);
      v(1, 1, 0,    0, ex(2, ""), 0);
      v(1, 1, 0,    0, ex(6, "E"), 0);
      v(0, 0, 0,    0, ex(6, "EN"), 0);
      v(1, 0, 0,    0, ex(0, "NP"), 0);
      v(1, 0, 0,    0, ex(0, ""), 0);

      foreach (vt[i]) begin
         @(negedge a);
         INTn = vt[i].intn; run = vt[i].run; ins = vt[i].ins; zero = vt[i].zero;
         #1;
         chk($sformatf("vec%0d_ctl", i), 32'(ob[0]), 32'(vt[i].e));
         chk($sformatf("vec%0d_retired", i), 32'(ret0), 32'(vt[i].ret));
      end
      chk("entry_point", ep[0], 32'd128);

      // Retire limit of 3 and 2-bit counter saturation over an addi stream.
      @(negedge a); INTn = 1'b0; run = 1'b0;
      @(negedge a); INTn = 1'b1; run = 1'b1; ins = ADDI;
      irw_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge a); #1;
         if (irw[1]) irw_cnt++;
      end
      chk("lim_retired", 32'(ret1), 32'd3);
      chk("lim_halted", 32'(hl[1]), 32'd1);
      chk("lim_state", 32'(st[1]), 32'd6);
      chk("lim_err", 32'(er[1]), 32'd0);
      chk("lim_irwrite_count", 32'(irw_cnt), 32'd3);
      chk("lim_pcwrite_halt", 32'(pcw[1]), 32'd0);
      chk("sat_retired", 32'(ret2), 32'd3);
      chk("sat_not_halted", 32'(hl[2]), 32'd0);
      chk("nolimit_u0_halted", 32'(hl[0]), 32'd0);

      hc = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge a);
         INTn = (c == 0) ? 1'b0 : (!(hc > 3) && ($urandom_range(0, 79) != 0));
         run  = ($urandom_range(0, 7) != 0);
         ins  = rnd_ins();
         zero = 1'($urandom_range(0, 1));
         #1;
         if (c > 0) begin
            e = model_obs(INTn);
            chk($sformatf("rnd%0d_ctl", c), 32'(ob[0]), 32'(e));
            chk($sformatf("rnd%0d_retired", c), 32'(ret0), 32'(m_ret));
         end
         model_edge(INTn, run, ins);
         hc = (m_st == 6) ? hc + 1 : 0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
